// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling FSM, single-word
// output register with valid/ready handshake, framing-error and overrun pulses.
module uart_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUDRATE    = 115200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rxd,
    output logic [DATA_WIDTH-1:0] axiod,
    output logic                  axiov,
    input  logic                  axior,
    output logic                  framing_err,
    output logic                  overrun
);

    // state  | meaning
    // IDLE   | line idle, waiting for a falling edge on rxs
    // START  | timing to the middle of the start bit, rejecting glitches
    // DATA   | sampling DATA_WIDTH bits, one per baud period, LSB first
    // STOP   | sampling the stop bit, then deliver or flag framing error

    localparam int BAUD_PERIOD = CLK_FREQ_HZ / BAUDRATE;
    localparam int HALF        = BAUD_PERIOD / 2;
    localparam int CNT_W       = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
    localparam int IDX_W       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(BAUD_PERIOD - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  rx_meta;
    logic                  rxs;
    logic                  rx_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            rx_prev     <= 1'b1;
            axiod       <= '0;
            axiov       <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            rx_meta     <= rxd;
            rxs         <= rx_meta;
            rx_prev     <= rxs;
            framing_err <= 1'b0;
            overrun     <= 1'b0;

            // A delivery in the same cycle below overrides this clear.
            if (axiov && axior)
                axiov <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_prev && !rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF_END) begin
                        if (!rxs) begin
                            state   <= DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_BIT_END) begin
                        shift_reg <= {rxs, shift_reg[DATA_WIDTH-1:1]};
                        cnt       <= '0;
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST)
                            state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_BIT_END) begin
                        state <= IDLE;
                        cnt   <= '0;
                        if (rxs) begin
                            if (!axiov || axior) begin
                                axiod <= shift_reg;
                                axiov <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            framing_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed line scenarios plus random frames,
// compared against a word-level model of delivery, overrun and framing errors.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int DW = 8;
    localparam int BP = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rxd = 1'b1;
    logic          axior = 1'b0;
    logic [DW-1:0] axiod;
    logic          axiov;
    logic          framing_err;
    logic          overrun;

    uart_rx #(.DATA_WIDTH(DW), .CLK_FREQ_HZ(100), .BAUDRATE(10)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rxd(rxd),
        .axiod(axiod),
        .axiov(axiov),
        .axior(axior),
        .framing_err(framing_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Observed behaviour, collected away from the active edge.
    int         cyc = 0;
    logic [7:0] rx_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         rise_cnt = 0;
    int         rise_cyc = 0;
    logic       prev_v = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (axiov && axior) rx_q.push_back(axiod);
        if (framing_err) fe_cnt = fe_cnt + 1;
        if (overrun) ov_cnt = ov_cnt + 1;
        if (axiov && !prev_v) begin
            rise_cnt = rise_cnt + 1;
            rise_cyc = cyc;
        end
        prev_v = axiov;
    end

    // Reference model: what words a consumer should see, and how many
    // overruns, framing errors and valid assertions should occur.
    logic [7:0] exp_q[$];
    int         exp_fe = 0;
    int         exp_ov = 0;
    int         exp_rise = 0;
    logic       m_held_v = 1'b0;
    logic [7:0] m_held = '0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_good(input logic [7:0] d);
        if (axior) begin
            exp_q.push_back(d);
            exp_rise++;
        end else if (m_held_v) begin
            exp_ov++;
        end else begin
            m_held_v = 1'b1;
            m_held   = d;
            exp_rise++;
        end
    endtask

    task automatic model_ready();
        if (m_held_v) begin
            exp_q.push_back(m_held);
            m_held_v = 1'b0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        tick(BP);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_nwords"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size())
                check({tag, "_word"}, 32'(rx_q[i]), 32'(exp_q[i]));
        check({tag, "_ferr"}, fe_cnt, exp_fe);
        check({tag, "_ovr"}, ov_cnt, exp_ov);
        check({tag, "_vrise"}, rise_cnt, exp_rise);
    endtask

    int         start_cyc;
    logic [7:0] rnd;

    initial begin
        // Reset state
        tick(3);
        check("rst_axiov", axiov, 0);
        check("rst_axiod", 32'(axiod), 0);
        check("rst_ferr", framing_err, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        tick(2 * BP);

        // Single frame with consumer ready, plus latency from the start edge
        axior = 1'b1;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1);
        model_good(8'hA5);
        tick(5);
        compare_all("a5");
        check("a5_latency_ok", ((rise_cyc - start_cyc) >= 96) && ((rise_cyc - start_cyc) <= 100), 1);
        check("a5_axiov_low", axiov, 0);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1);
        model_good(8'h00);
        send_frame(8'hFF, 1'b1);
        model_good(8'hFF);
        tick(5);
        compare_all("b2b");

        // Consumer stalled: second word dropped with an overrun
        axior = 1'b0;
        send_frame(8'h3C, 1'b1);
        model_good(8'h3C);
        send_frame(8'hC3, 1'b1);
        model_good(8'hC3);
        tick(5);
        check("stall_axiov", axiov, 1);
        check("stall_axiod", 32'(axiod), 32'h3C);
        compare_all("stall");
        axior = 1'b1;
        model_ready();
        tick(2);
        check("drain_axiov", axiov, 0);
        tick(BP);
        compare_all("drain");

        // Bad stop bit, then a held-low line that must not retrigger
        send_frame(8'h55, 1'b0);
        exp_fe++;
        tick(5);
        check("ferr_axiov", axiov, 0);
        compare_all("ferr");
        tick(3 * BP);
        compare_all("held_low");
        send_bit(1'b1);
        send_frame(8'h96, 1'b1);
        model_good(8'h96);
        tick(5);
        compare_all("after_low");

        // Short low glitch on an idle line
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(3 * BP);
        compare_all("glitch");

        // Reset mid-frame with a word pending: everything clears at once
        axior = 1'b0;
        send_frame(8'h81, 1'b1);
        model_good(8'h81);
        tick(5);
        check("pre_rst_axiov", axiov, 1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(rnd_bit(8'h81, i));
        rxd = 1'b0;
        tick(3);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_axiov", axiov, 0);
        check("midrst_axiod", 32'(axiod), 0);
        check("midrst_ferr", framing_err, 0);
        check("midrst_ovr", overrun, 0);
        m_held_v = 1'b0;
        rxd = 1'b1;
        tick(3);
        @(negedge clk);
        rst_n = 1'b1;
        tick(2 * BP);
        axior = 1'b1;
        send_frame(8'h81, 1'b1);
        model_good(8'h81);
        tick(5);
        compare_all("post_rst");

        // Random frames with random idle gaps
        for (int n = 0; n < 8; n++) begin
            rnd = 8'($urandom_range(0, 255));
            send_frame(rnd, 1'b1);
            model_good(rnd);
            tick($urandom_range(0, 15));
        end
        tick(5);
        compare_all("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    function automatic logic rnd_bit(input logic [7:0] d, input int i);
        return d[i];
    endfunction

endmodule
